// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among NREQ message sources
module uart_tx_arbiter #(
    parameter int NREQ         = 3,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        tx_data,
    output logic              tx_data_valid,
    input  logic              tx_busy,
    output logic              active
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   next_ptr;
    logic            pick_found;
    logic [CW-1:0]   to_cnt;
    logic            last_flag;
    logic [7:0]      own_data;

    // First requesting source at or above rr_ptr, wrapping; the lowest offset wins
    always_comb begin
        pick       = '0;
        idx        = '0;
        pick_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    // Byte lane of the current owner
    always_comb begin
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                own_data = req_data[8*i +: 8];
            end
        end
    end

    assign next_ptr = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

    // Arbitration and byte handshake state machine; every output is registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            to_cnt        <= '0;
            last_flag     <= 1'b0;
            grant         <= '0;
            active        <= 1'b0;
            req_ready     <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
        end else begin
            tx_data_valid <= 1'b0;
            req_ready     <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner  <= pick;
                        grant  <= NREQ'(1) << pick;
                        active <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (req_valid[owner] && !tx_busy) begin
                        tx_data       <= own_data;
                        tx_data_valid <= 1'b1;
                        req_ready     <= NREQ'(1) << owner;
                        last_flag     <= req_last[owner];
                        to_cnt        <= '0;
                        state         <= WAIT_HI;
                    end else if (!req[owner] && !req_valid[owner]) begin
                        grant  <= '0;
                        active <= 1'b0;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                WAIT_HI: begin
                    // uart_tx may never raise busy; give up waiting after BUSY_TIMEOUT cycles
                    if (tx_busy || to_cnt == CW'(BUSY_TIMEOUT - 1)) begin
                        state <= WAIT_LO;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last_flag || !req[owner]) begin
                            grant  <= '0;
                            active <= 1'b0;
                            rr_ptr <= next_ptr;
                            state  <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of message requesters sharing one uart_tx (2..8).
REQ-002 Parameter BUSY_TIMEOUT, default 16: cycles to wait for tx_busy rise before treating the byte as done.
REQ-003 clk  input  1  system clock, 12 MHz; all logic on the rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 req  input  NREQ  per-requester message request; held high for the whole message.
REQ-006 req_data  input  8*NREQ  byte from requester i in bits [8i+7:8i].
REQ-007 req_valid  input  NREQ  requester i has a byte on req_data; held until req_ready[i].
REQ-008 req_last  input  NREQ  qualifies req_valid: the byte is the final byte of the message.
REQ-009 req_ready  output  NREQ  one-cycle pulse: byte from requester i accepted.
REQ-010 grant  output  NREQ  one-hot (or zero) owner of the transmitter.
REQ-011 tx_data  output  8  byte to uart_tx.
REQ-012 tx_data_valid  output  1  one-cycle load pulse to uart_tx.
REQ-013 tx_busy  input  1  uart_tx busy flag.
REQ-014 active  output  1  high whenever grant is non-zero.

Function
REQ-015 States: IDLE, SEND, WAIT_HI, WAIT_LO; all outputs registered.
REQ-016 IDLE: grant=0; if any req bit is high, the block grants the first set bit searching upward from rr_ptr with wrap NREQ-1 -> 0, and enters SEND next cycle.
REQ-017 Latency: req rises in IDLE at cycle N -> grant one-hot at N+1 -> earliest tx_data_valid at N+2.
REQ-018 SEND, owner g: if req_valid[g]=1 and tx_busy=0, the block drives tx_data=req_data[g], tx_data_valid=1 and req_ready[g]=1 in the same single cycle, latches last_flag=req_last[g], and enters WAIT_HI.
REQ-019 SEND with req_valid[g]=0 and req[g]=1: the block holds SEND with no timeout.
REQ-020 SEND with req[g]=0 and no byte pending: the block releases.
REQ-021 WAIT_HI: the block advances to WAIT_LO on tx_busy=1 or after BUSY_TIMEOUT cycles, whichever is first; the timeout counter clears on entry.
REQ-022 WAIT_LO: on tx_busy=0, if last_flag=1 or req[g]=0 the block releases; otherwise it returns to SEND.
REQ-023 Release: grant=0, rr_ptr=(g+1) mod NREQ, state IDLE; a new arbitration takes effect at the earliest on the cycle after release (no back-to-back grant in the release cycle).
REQ-024 If req[g] drops while in WAIT_HI or WAIT_LO, the in-flight byte completes; release then follows per REQ-022.
REQ-025 req_ready is never asserted for a non-owner; req_valid from non-owners is ignored.
REQ-026 tx_data holds its last value between pulses; tx_data_valid is never high in two consecutive cycles.
REQ-027 Simultaneous requests: only one grant per arbitration; rr_ptr guarantees each continuously requesting source is served within NREQ messages.
REQ-028 req_last=1 on the first byte gives a single-byte message and is legal.

Reset
REQ-029 When rst_n=0 at a clock edge: state=IDLE, grant=0, req_ready=0, tx_data=0, tx_data_valid=0, active=0, rr_ptr=0, timeout counter=0, last_flag=0.
REQ-030 Reset mid-message aborts without completing the byte or pulsing req_ready; the first post-reset arbitration starts from requester 0.

Verification
REQ-031 Single requester: req[0]=1, three bytes 0x43,0x48,0x0A (last on 0x0A), uart_tx model busy 10 cycles/byte -> exactly three tx_data_valid pulses in order, grant=001 throughout, release after the third busy fall, rr_ptr=1.
REQ-032 Contention: req=111 from idle with rr_ptr=0, each sending 2-byte messages -> service order 0,1,2,0; no interleaving of bytes between owners.
REQ-033 Busy timeout: tx_busy tied 0, BUSY_TIMEOUT=16 -> consecutive tx_data_valid pulses spaced 18 cycles (SEND + 16 WAIT_HI + WAIT_LO), message completes.
REQ-034 Abort: owner 1 drops req after its first byte while tx_busy is high -> byte finishes, grant=000 after tx_busy falls, no second req_ready, rr_ptr=2.
REQ-035 Reset mid-byte: rst_n=0 one cycle during WAIT_LO of owner 2 -> next cycle all outputs 0; a subsequent req=110 is granted to requester 1.
REQ-036 Invariants: grant always zero or one-hot; tx_data_valid implies exactly one req_ready bit high; active equals (grant != 0).
